// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the MMIO UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_BAUDDIV = 2'd2;

    localparam int STAT_EMPTY_BIT    = 0;
    localparam int STAT_FULL_BIT     = 1;
    localparam int STAT_BUSY_BIT     = 2;
    localparam int STAT_OVERFLOW_BIT = 3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrapping pointers and separate occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // Push is refused while full even if a pop happens on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and programmable bit period
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter int          DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] dev_addr,
    input  logic        dev_re,
    output logic [31:0] dev_rd,
    input  logic        dev_we,
    input  logic [31:0] dev_wd,
    output logic        dev_rw,
    output logic        tx,
    output logic        irq
);

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    uart_tx_state_t state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0] cyc_q, cyc_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 overflow_q, overflow_d;
    logic                 tx_q, tx_d;
    logic                 irq_q, irq_d;

    logic [1:0]                    reg_idx;
    logic                          wr_txdata, wr_status, wr_bauddiv;
    logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                    fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          busy, bit_done;
    logic [DIV_WIDTH-1:0]          eff_div;
    logic                          unused_inputs;

    assign reg_idx    = dev_addr[3:2];
    assign wr_txdata  = dev_we & (reg_idx == UART_REG_TXDATA);
    assign wr_status  = dev_we & (reg_idx == UART_REG_STATUS);
    assign wr_bauddiv = dev_we & (reg_idx == UART_REG_BAUDDIV);
    assign fifo_push  = wr_txdata & ~fifo_full;
    assign busy       = (state_q != TX_IDLE);
    assign bit_done   = (cyc_q == period_q - DIV_ONE);
    assign eff_div    = (div_q == '0) ? DIV_ONE : div_q;

    assign dev_rw = 1'b1;
    assign tx     = tx_q;
    assign irq    = irq_q;

    assign unused_inputs = ^{dev_re, dev_addr[31:4], dev_wd, fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (dev_wd[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        dev_rd = '0;
        case (reg_idx)
            UART_REG_STATUS: begin
                dev_rd[STAT_EMPTY_BIT]    = fifo_empty;
                dev_rd[STAT_FULL_BIT]     = fifo_full;
                dev_rd[STAT_BUSY_BIT]     = busy;
                dev_rd[STAT_OVERFLOW_BIT] = overflow_q;
            end
            UART_REG_BAUDDIV: dev_rd = 32'(div_q);
            default:          dev_rd = '0;
        endcase
    end

    // A drop on the same edge as a clear leaves overflow set.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_status && dev_wd[STAT_OVERFLOW_BIT]) overflow_d = 1'b0;
        if (wr_txdata && fifo_full)                 overflow_d = 1'b1;
        div_d = wr_bauddiv ? dev_wd[DIV_WIDTH-1:0] : div_q;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        cyc_d     = cyc_q;
        period_d  = period_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    period_d  = eff_div;
                    cyc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    cyc_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cyc_d = cyc_q + DIV_ONE;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    cyc_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = TX_STOP;
                end else begin
                    cyc_d = cyc_q + DIV_ONE;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    cyc_d = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_rdata;
                        period_d  = eff_div;
                        bit_cnt_d = '0;
                        state_d   = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + DIV_ONE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        irq_d = fifo_empty & ~busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cyc_q      <= '0;
            period_q   <= '0;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_q      <= cyc_d;
            period_q   <= period_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench comparing the serial waveform against a frame-level model
module tb_mmio_uart_tx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:2] dev_addr = '0;
    logic        dev_re = 1'b0;
    logic [31:0] dev_rd;
    logic        dev_we = 1'b0;
    logic [31:0] dev_wd = '0;
    logic        dev_rw;
    logic        tx;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] frame_bytes [$];

    mmio_uart_tx #(
        .FIFO_DEPTH  (16),
        .DIV_WIDTH   (16),
        .DEFAULT_DIV (434)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dev_addr (dev_addr),
        .dev_re   (dev_re),
        .dev_rd   (dev_rd),
        .dev_we   (dev_we),
        .dev_wd   (dev_wd),
        .dev_rw   (dev_rw),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a clock edge; returns 1 ns after the edge that accepted the write.
    task automatic mmio_write(input logic [1:0] idx, input logic [31:0] data);
        dev_addr      = '0;
        dev_addr[3:2] = idx;
        dev_wd        = data;
        dev_we        = 1'b1;
        @(posedge clk);
        #1;
        dev_we = 1'b0;
    endtask

    task automatic mmio_read(input logic [1:0] idx, output logic [31:0] data);
        dev_we        = 1'b0;
        dev_re        = 1'b1;
        dev_addr      = '0;
        dev_addr[3:2] = idx;
        #1;
        data   = dev_rd;
        dev_re = 1'b0;
    endtask

    // Model: each byte becomes start(0), 8 data bits LSB first, stop(1), each held d cycles.
    task automatic run_frames(input int div);
        int d, total, k0, j;
        logic [31:0] r;
        bit exp_bits [$];
        d = (div == 0) ? 1 : div;
        exp_bits = {};
        foreach (frame_bytes[i]) begin
            for (int c = 0; c < d; c++) exp_bits.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < d; c++) exp_bits.push_back(frame_bytes[i][b]);
            for (int c = 0; c < d; c++) exp_bits.push_back(1'b1);
        end
        total = exp_bits.size();
        k0 = 0;
        mmio_write(UART_REG_BAUDDIV, 32'(div));
        foreach (frame_bytes[i]) begin
            r = $urandom();
            r[7:0] = frame_bytes[i];
            mmio_write(UART_REG_TXDATA, r);
            if (i == 0) begin
                k0 = cyc;
                check_eq("irq_after_first_push", {31'b0, irq}, 32'd1);
            end
        end
        while (1) begin
            @(negedge clk);
            j = cyc - k0 - 1;
            if (j >= total + 2) break;
            if (j >= 0 && j < total) begin
                check_eq("tx_bit", {31'b0, tx}, {31'b0, exp_bits[j]});
                check_eq("irq_busy", {31'b0, irq}, 32'd0);
            end else if (j == total) begin
                check_eq("tx_idle", {31'b0, tx}, 32'd1);
            end else if (j == total + 1) begin
                check_eq("tx_idle2", {31'b0, tx}, 32'd1);
                check_eq("irq_done", {31'b0, irq}, 32'd1);
                mmio_read(UART_REG_STATUS, r);
                check_eq("status_done", r, 32'h1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        int div, n;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_irq", {31'b0, irq}, 32'd1);
        check_eq("rw_tied", {31'b0, dev_rw}, 32'd1);
        mmio_read(UART_REG_STATUS, r);   check_eq("rst_status", r, 32'h1);
        mmio_read(UART_REG_BAUDDIV, r);  check_eq("rst_bauddiv", r, 32'd434);
        mmio_read(UART_REG_TXDATA, r);   check_eq("txdata_reads_0", r, 32'h0);
        @(posedge clk); #1;
        mmio_write(2'd3, 32'hFFFF_FFFF);
        mmio_read(2'd3, r);              check_eq("idx3_reads_0", r, 32'h0);
        mmio_read(UART_REG_BAUDDIV, r);  check_eq("idx3_no_effect_div", r, 32'd434);
        mmio_read(UART_REG_STATUS, r);   check_eq("idx3_no_effect_stat", r, 32'h1);
        @(posedge clk); #1;

        frame_bytes = {8'h55};
        run_frames(4);
        frame_bytes = {8'hA1, 8'h3C};
        run_frames(2);
        frame_bytes = {8'hFF};
        run_frames(0);
        mmio_read(UART_REG_BAUDDIV, r);  check_eq("bauddiv_zero_rd", r, 32'd0);
        @(posedge clk); #1;

        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 5);
            n   = $urandom_range(1, 4);
            frame_bytes = {};
            for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom()));
            run_frames(div);
        end

        mmio_write(UART_REG_BAUDDIV, 32'hFFFF_0064);
        mmio_read(UART_REG_BAUDDIV, r);  check_eq("bauddiv_masked", r, 32'h64);
        @(posedge clk); #1;
        mmio_write(UART_REG_TXDATA, 32'h0000_0000);
        for (int i = 0; i < 17; i++) mmio_write(UART_REG_TXDATA, $urandom());
        mmio_read(UART_REG_STATUS, r);   check_eq("status_overflow", r, 32'hE);
        @(posedge clk); #1;
        mmio_write(UART_REG_STATUS, 32'h8);
        mmio_read(UART_REG_STATUS, r);   check_eq("status_ovf_cleared", r, 32'h6);
        check_eq("tx_start_bit", {31'b0, tx}, 32'd0);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_eq("rst_async_tx", {31'b0, tx}, 32'd1);
        mmio_read(UART_REG_STATUS, r);   check_eq("rst_mid_status", r, 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mmio_read(UART_REG_STATUS, r);   check_eq("post_rst_status", r, 32'h1);
        mmio_read(UART_REG_BAUDDIV, r);  check_eq("post_rst_bauddiv", r, 32'd434);
        check_eq("post_rst_tx", {31'b0, tx}, 32'd1);
        check_eq("post_rst_irq", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;

        frame_bytes = {8'h5A};
        run_frames(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
